// File: rtl/knn_win_scan_pkg.sv
// knn_pkg: shared FSM state type, coordinate type and default geometry
// for the KNN window scanner and the compare engine it feeds.
package knn_pkg;

    localparam int KNN_COORD_W = 10;
    localparam int KNN_IMG_W   = 640;
    localparam int KNN_IMG_H   = 480;

    typedef logic [KNN_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/knn_win_scan_if.sv
// knn_win_scan_if: point stream from the window scanner (master) to the
// dictionary-compare engine (slave), valid/ready handshake.
interface knn_win_scan_if import knn_pkg::*; #(
    parameter int COORD_W = KNN_COORD_W
);

    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               pt_first;
    logic               pt_last;

    modport master (
        output pt_valid, pt_x, pt_y, pt_first, pt_last,
        input  pt_ready
    );

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_first, pt_last,
        output pt_ready
    );

endinterface

// File: rtl/knn_win_scan_origin_calc.sv
// knn_origin_calc: box centre and window origin, purely combinational.
// Build option: define KNN_CLAMP_EN to keep the whole window inside the
// image; otherwise the origin is the raw modulo-2^COORD_W difference.
module knn_origin_calc import knn_pkg::*; #(
    parameter int COORD_W = KNN_COORD_W,
    parameter int WIN_W   = 8,
    parameter int WIN_H   = 8,
    parameter int IMG_W   = KNN_IMG_W,
    parameter int IMG_H   = KNN_IMG_H
) (
    input  logic [COORD_W-1:0] lu_x,
    input  logic [COORD_W-1:0] lu_y,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic [COORD_W-1:0] ox,
    output logic [COORD_W-1:0] oy
);

`ifdef KNN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [COORD_W:0] HALF_W = (COORD_W+1)'(WIN_W / 2);
    localparam logic [COORD_W:0] HALF_H = (COORD_W+1)'(WIN_H / 2);
    localparam logic [COORD_W:0] MAX_OX = (COORD_W+1)'(IMG_W - WIN_W);
    localparam logic [COORD_W:0] MAX_OY = (COORD_W+1)'(IMG_H - WIN_H);

    logic [COORD_W:0] sum_x;
    logic [COORD_W:0] sum_y;
    logic [COORD_W:0] cx;
    logic [COORD_W:0] cy;

    // Centre minus half window; the clamp compares on the unsigned centre
    // so a would-be negative origin is caught before it wraps.
    function automatic logic [COORD_W-1:0] place(
        input logic [COORD_W:0] c,
        input logic [COORD_W:0] half,
        input logic [COORD_W:0] max_o
    );
        logic [COORD_W:0] d;
        d = c - half;
        if (!CLAMP_EN) return d[COORD_W-1:0];
        if (c < half)  return '0;
        if (d > max_o) return max_o[COORD_W-1:0];
        return d[COORD_W-1:0];
    endfunction

    // Centre at COORD_W+1 bits so the sum never overflows, then origin.
    always_comb begin
        sum_x = {1'b0, lu_x} + {1'b0, rd_x};
        sum_y = {1'b0, lu_y} + {1'b0, rd_y};
        cx    = sum_x >> 1;
        cy    = sum_y >> 1;
        ox    = place(cx, HALF_W, MAX_OX);
        oy    = place(cy, HALF_H, MAX_OY);
    end

endmodule

// File: rtl/knn_win_scan.sv
// knn_win_scan: on a knn_en rising edge, latch a window origin around the
// box centre and stream WIN_W x WIN_H points in raster order over a
// valid/ready interface, with abort and first/last markers.
// Build option: KNN_CLAMP_EN (see knn_origin_calc).
module knn_win_scan import knn_pkg::*; #(
    parameter int COORD_W = KNN_COORD_W,
    parameter int WIN_W   = 8,
    parameter int WIN_H   = 8,
    parameter int IMG_W   = KNN_IMG_W,
    parameter int IMG_H   = KNN_IMG_H
) (
    input  logic               clk_en,
    input  logic               reset_n,
    input  logic               knn_en,
    input  logic               abort,
    input  logic [COORD_W-1:0] pos_lu_x,
    input  logic [COORD_W-1:0] pos_lu_y,
    input  logic [COORD_W-1:0] pos_rd_x,
    input  logic [COORD_W-1:0] pos_rd_y,
    knn_win_scan_if.master     pt,
    output logic               busy,
    output logic               knn_fin
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIN_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(WIN_H - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    scan_state_t        state;
    logic               knn_en_q;
    logic [COORD_W-1:0] ox;
    logic [COORD_W-1:0] oy;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] org_x;
    logic [COORD_W-1:0] org_y;
    logic [COORD_W-1:0] col_nxt;
    logic [COORD_W-1:0] row_nxt;
    logic               start;
    logic               accept;
    logic               at_row_end;

    knn_origin_calc #(
        .COORD_W (COORD_W),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H)
    ) u_origin (
        .lu_x (pos_lu_x),
        .lu_y (pos_lu_y),
        .rd_x (pos_rd_x),
        .rd_y (pos_rd_y),
        .ox   (org_x),
        .oy   (org_y)
    );

    // Edge detect, handshake and the raster step to the next point.
    always_comb begin
        start      = knn_en & ~knn_en_q;
        accept     = pt.pt_valid & pt.pt_ready;
        at_row_end = (col == LAST_COL);
        col_nxt    = at_row_end ? '0 : col + ONE;
        row_nxt    = at_row_end ? row + ONE : row;
    end

    // Scan FSM; point outputs are registered one step ahead from col_nxt/
    // row_nxt so they change only on an accepted handshake.
    always_ff @(posedge clk_en) begin
        if (!reset_n) begin
            state       <= IDLE;
            knn_en_q    <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            col         <= '0;
            row         <= '0;
            pt.pt_valid <= 1'b0;
            pt.pt_x     <= '0;
            pt.pt_y     <= '0;
            pt.pt_first <= 1'b0;
            pt.pt_last  <= 1'b0;
            busy        <= 1'b0;
            knn_fin     <= 1'b0;
        end else begin
            knn_en_q <= knn_en;
            knn_fin  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ox          <= org_x;
                        oy          <= org_y;
                        col         <= '0;
                        row         <= '0;
                        pt.pt_x     <= org_x;
                        pt.pt_y     <= org_y;
                        pt.pt_first <= 1'b1;
                        pt.pt_last  <= (LAST_COL == '0) && (LAST_ROW == '0);
                        pt.pt_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        pt.pt_valid <= 1'b0;
                        pt.pt_first <= 1'b0;
                        pt.pt_last  <= 1'b0;
                    end else if (accept) begin
                        if (pt.pt_last) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            knn_fin     <= 1'b1;
                            pt.pt_valid <= 1'b0;
                            pt.pt_first <= 1'b0;
                            pt.pt_last  <= 1'b0;
                        end else begin
                            col         <= col_nxt;
                            row         <= row_nxt;
                            pt.pt_x     <= ox + col_nxt;
                            pt.pt_y     <= oy + row_nxt;
                            pt.pt_first <= 1'b0;
                            pt.pt_last  <= (col_nxt == LAST_COL) && (row_nxt == LAST_ROW);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
